// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared widths, halt opcode and fetch state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package instr_fetch_pkg;

    localparam int          c_PC_W        = 8;
    localparam int          c_INSTR_W     = 32;
    localparam logic [31:0] c_HALT_OPCODE = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        FS_RUN    = 1'b0,
        FS_HALTED = 1'b1
    } fetch_state_t;

endpackage : instr_fetch_pkg
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : ROM read port, decode handshake and redirect bundle of fetch.
// Revision    : 1.0  initial release
// ============================================================================
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int PC_W    = c_PC_W,
    parameter int INSTR_W = c_INSTR_W
);
    logic [PC_W-1:0]    pc_o;
    logic [INSTR_W-1:0] instr_i;
    logic [INSTR_W-1:0] instr_o;
    logic [PC_W-1:0]    instr_pc_o;
    logic               instr_valid_o;
    logic               instr_ready_i;
    logic               redirect_i;
    logic [PC_W-1:0]    redirect_pc_i;
    logic               halted_o;

    // Fetch unit side
    modport master (
        output pc_o, instr_o, instr_pc_o, instr_valid_o, halted_o,
        input  instr_i, instr_ready_i, redirect_i, redirect_pc_i
    );

    // ROM / decode / execute side
    modport slave (
        input  pc_o, instr_o, instr_pc_o, instr_valid_o, halted_o,
        output instr_i, instr_ready_i, redirect_i, redirect_pc_i
    );

endinterface : instr_fetch_if
`default_nettype wire

// File: rtl/instr_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_fifo
// Description : Synchronous FIFO with push/pop/flush; flush beats push.
// Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic             flush,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_count;

    logic w_pop;
    logic w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == c_CW'(DEPTH));
    assign w_pop  = pop & ~empty;
    // A full FIFO can still accept when the head leaves in the same cycle.
    assign w_push = push & (~full | w_pop);
    assign dout   = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= din;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : instr_fetch_fifo
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : PC owner, ROM read initiator and fetch buffer towards decode.
//               Optional halt-on-opcode stop enabled by FETCH_HALT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int              PC_W       = c_PC_W,
    parameter int              INSTR_W    = c_INSTR_W,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  wire logic   clk,
    input  wire logic   rst,
    instr_fetch_if.master bus
);

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_is_halt;

    assign w_pop  = ~w_empty & bus.instr_ready_i & ~bus.redirect_i;
    assign w_push = (r_state == FS_RUN) & ~bus.redirect_i & (~w_full | w_pop);

`ifdef FETCH_HALT_EN
    logic r_halted;
    assign w_is_halt    = (bus.instr_i == INSTR_W'(c_HALT_OPCODE));
    assign bus.halted_o = r_halted;
`else
    assign w_is_halt    = 1'b0;
    assign bus.halted_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_state <= FS_RUN;
`ifdef FETCH_HALT_EN
            r_halted <= 1'b0;
`endif
        end else if (bus.redirect_i) begin
            r_pc    <= bus.redirect_pc_i;
            r_state <= FS_RUN;
`ifdef FETCH_HALT_EN
            r_halted <= 1'b0;
`endif
        end else if (w_push) begin
            // The halt word is still buffered, but PC parks on its address.
            if (w_is_halt) begin
                r_state <= FS_HALTED;
`ifdef FETCH_HALT_EN
                r_halted <= 1'b1;
`endif
            end else begin
                r_pc <= r_pc + 1'b1;
            end
        end
    end

    assign bus.pc_o          = r_pc;
    assign bus.instr_valid_o = ~w_empty;

    instr_fetch_fifo #(
        .WIDTH (PC_W + INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (bus.redirect_i),
        .din   ({r_pc, bus.instr_i}),
        .dout  ({bus.instr_pc_o, bus.instr_o}),
        .full  (w_full),
        .empty (w_empty)
    );

endmodule : instr_fetch
`default_nettype wire
